pipelined_adder: RTL
====================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, meaning the number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand set present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts an operand set this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits: first operand.
REQ-008 The block SHALL have port b, input, WIDTH bits: second operand.
REQ-009 The block SHALL have port cin, input, 1 bit: carry in.
REQ-010 The block SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result this cycle.
REQ-013 The block SHALL have port z, output, WIDTH bits: result.
REQ-014 The block SHALL have port nzcv, output, 4 bits: flags {N, Z, C, V}.

Function
REQ-015 A transfer SHALL occur on a rising edge where the valid and ready of the same port are both 1; there SHALL be no transfer otherwise.
REQ-016 With sub=0 the result SHALL be a+b+cin; with sub=1 it SHALL be a+~b+cin (cin=1 means no borrow).
REQ-017 The adder SHALL be split into STAGES slices of WIDTH/STAGES bits; stage k SHALL add slice k and register the inter-slice carry for stage k+1.
REQ-018 Latency SHALL be exactly STAGES cycles from the input transfer to out_valid when out_ready stays 1.
REQ-019 Throughput SHALL be one operation per cycle when out_ready stays 1.
REQ-020 Results SHALL emerge in acceptance order, with none lost or duplicated.
REQ-021 Each stage SHALL hold its contents while its successor is full and stalled.
REQ-022 A stage SHALL load when it is empty or its successor advances; in_ready SHALL equal stage-0-empty OR stage-0-advancing.
REQ-023 When the pipeline is full and out_ready=0, in_ready SHALL be 0; exactly STAGES operations SHALL be buffered.
REQ-024 Simultaneous output transfer and input transfer on a full pipeline SHALL both complete in the same cycle.
REQ-025 N SHALL be z[WIDTH-1]; Z SHALL be 1 when z equals 0.
REQ-026 C SHALL be the carry out of bit WIDTH-1.
REQ-027 V SHALL be the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-028 z and nzcv SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-029 While rst_n=0, every stage valid, out_valid, z and nzcv SHALL be 0, and in_ready SHALL be 1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations immediately, with no partial result emitted after release.
REQ-031 The first input transfer SHALL be possible on the first rising edge after rst_n rises.

Structure
REQ-032 The flag bit indices (N=3, Z=2, C=1, V=0) SHALL be defined once in a shared package/header used by this block and by the ALU and flag logic.
REQ-033 A single sub-module adder_pipe_stage SHALL implement one slice adder, carry register, and valid/ready hold logic, instantiated STAGES times through generate.

Verification (WIDTH=8, STAGES=4)
REQ-034 Stimulus a=200, b=100, cin=0, sub=0 SHALL produce, 4 cycles later, z=44 and nzcv=0010.
REQ-035 Stimulus a=127, b=1, cin=0, sub=0 SHALL produce z=128 and nzcv=1001.
REQ-036 Stimulus a=5, b=5, cin=1, sub=1 SHALL produce z=0 and nzcv=0110.
REQ-037 Twenty $random operand sets streamed back-to-back with out_ready=1 SHALL yield one result per cycle after 4 cycles, each matching a+b+cin.
REQ-038 Six inputs offered with out_ready=0 for 10 cycles SHALL have exactly 4 accepted, in_ready=0 and outputs stable; after out_ready=1 all 6 SHALL emerge in order.
REQ-039 rst_n pulsed low with 3 operations in flight SHALL give out_valid=0 with no stale result afterwards, and a new operation SHALL return correctly.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - flag bit positions shared by adder, ALU and flag logic
// Contents: FLAG_* indices into the 4-bit nzcv vector and the pack_nzcv() helper.
package pipelined_adder_pkg;

    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [FLAG_W-1:0] pack_nzcv(
        input logic n,
        input logic zf,
        input logic c,
        input logic v
    );
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = zf;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// rtl/pipelined_adder_stage.sv - one slice adder with carry register and valid/ready hold
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   up_valid/up_ready          handshake with the previous stage (or block input)
//   up_a, up_b, up_z, up_carry operands (b already conditioned), partial result, carry into this slice
//   dn_valid/dn_ready          handshake with the next stage (or block output)
//   dn_a, dn_b, dn_z, dn_carry registered operands, partial result with this slice filled, carry out
module adder_pipe_stage #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int INDEX = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic [WIDTH-1:0] up_z,
    input  logic             up_carry,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_a,
    output logic [WIDTH-1:0] dn_b,
    output logic [WIDTH-1:0] dn_z,
    output logic             dn_carry
);

    localparam int LO = INDEX * SLICE;

    logic             valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] z_q;
    logic             carry_q;
    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] z_next;
    logic             load;

    assign slice_sum = {1'b0, up_a[LO +: SLICE]} + {1'b0, up_b[LO +: SLICE]}
                     + {{SLICE{1'b0}}, up_carry};

    always_comb begin
        z_next                = up_z;
        z_next[LO +: SLICE]   = slice_sum[SLICE-1:0];
    end

    // Room for a new entry when empty, or when the current one leaves this cycle.
    assign up_ready = !valid_q || dn_ready;
    assign load     = up_ready && up_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            if (up_ready) begin
                valid_q <= up_valid;
            end
            // Data only moves on a real transfer so a stalled result stays put.
            if (load) begin
                a_q     <= up_a;
                b_q     <= up_b;
                z_q     <= z_next;
                carry_q <= slice_sum[SLICE];
            end
        end
    end

    assign dn_valid = valid_q;
    assign dn_a     = a_q;
    assign dn_b     = b_q;
    assign dn_z     = z_q;
    assign dn_carry = carry_q;

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - carry-staggered pipelined add/subtract with NZCV flags
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake; a, b, cin, sub travel with it
//   out_valid/out_ready     result handshake; z and nzcv ({N,Z,C,V}) travel with it
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  z,
    output logic [FLAG_W-1:0] nzcv
);

    localparam int SLICE = WIDTH / STAGES;

    // Element k feeds stage k; element STAGES is the output of the last stage.
    logic             v_chain [STAGES+1];
    logic             r_chain [STAGES+1];
    logic [WIDTH-1:0] a_chain [STAGES+1];
    logic [WIDTH-1:0] b_chain [STAGES+1];
    logic [WIDTH-1:0] z_chain [STAGES+1];
    logic             c_chain [STAGES+1];

    assign v_chain[0]      = in_valid;
    assign a_chain[0]      = a;
    assign b_chain[0]      = sub ? ~b : b;
    assign z_chain[0]      = '0;
    assign c_chain[0]      = cin;
    assign r_chain[STAGES] = out_ready;
    assign in_ready        = r_chain[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_stage #(
            .WIDTH (WIDTH),
            .SLICE (SLICE),
            .INDEX (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (v_chain[k]),
            .up_ready (r_chain[k]),
            .up_a     (a_chain[k]),
            .up_b     (b_chain[k]),
            .up_z     (z_chain[k]),
            .up_carry (c_chain[k]),
            .dn_valid (v_chain[k+1]),
            .dn_ready (r_chain[k+1]),
            .dn_a     (a_chain[k+1]),
            .dn_b     (b_chain[k+1]),
            .dn_z     (z_chain[k+1]),
            .dn_carry (c_chain[k+1])
        );
    end

    logic msb_carry_in;
    logic carry_out;

    // The sum bit is a^b^carry-in, so the carry into the MSB falls out without a second adder.
    assign msb_carry_in = z_chain[STAGES][WIDTH-1] ^ a_chain[STAGES][WIDTH-1]
                        ^ b_chain[STAGES][WIDTH-1];
    assign carry_out    = c_chain[STAGES];

    assign out_valid = v_chain[STAGES];
    assign z         = z_chain[STAGES];
    // Gated by out_valid so an empty pipe (z=0) does not report Z=1.
    assign nzcv      = out_valid
                     ? pack_nzcv(z[WIDTH-1], (z == '0), carry_out, carry_out ^ msb_carry_in)
                     : '0;

endmodule
